reg_bank_writeback: RTL
=======================

// Module: reg_bank_writeback
// PURPOSE
//  Write-side front end of Reg_Bank. Merges two result streams into the single Reg_Bank write port (WE3/A3/WD3):
//  - single-cycle ALU results, highest priority, never stalled;
//  - load results, via a valid/ready handshake, buffered in a small FIFO.
//  Drops writes to x0, resolves WAW between a pending load and a younger ALU write, and exports a pending-load mask for stall logic.
// PARAMETERS
//  XLEN      32  data width of results and WD3
//  REG_AW    5   register address width (2**REG_AW registers)
//  LQ_DEPTH  4   load-queue entries, power of 2, >=2
// PORTS
//  clk         in   1          clock, all state updates on posedge
//  rst         in   1          synchronous reset, active-high
//  alu_valid   in   1          ALU result present this cycle
//  alu_rd      in   REG_AW     ALU destination register
//  alu_data    in   XLEN       ALU result
//  ld_valid    in   1          load result offered
//  ld_ready    out  1          load result accepted when ld_valid&&ld_ready
//  ld_rd       in   REG_AW     load destination register
//  ld_data     in   XLEN       load data
//  WE3         out  1          to Reg_Bank write enable (registered)
//  A3          out  REG_AW     to Reg_Bank write address (registered)
//  WD3         out  XLEN       to Reg_Bank write data (registered)
//  lq_count    out  $clog2(LQ_DEPTH)+1  occupied queue entries
//  ld_pend     out  2**REG_AW  bit r set while a live queued load targets xr
// BEHAVIOUR
//  Reset: WE3=0, A3=0, WD3=0, lq_count=0, ld_pend=0, pointers=0; queue contents discarded. Reset mid-operation loses all queued loads, with no write issued.
//  ld_ready = (lq_count != LQ_DEPTH), combinational from count only. A full queue refuses loads even in a cycle it pops.
//  Accept: a load with ld_rd==0 is accepted and discarded, not enqueued. Any other load is enqueued as {live=1, rd, data}.
//  Select (each posedge):
//  - alu_valid && alu_rd!=0 -> WE3<=1, A3<=alu_rd, WD3<=alu_data; the queue does not pop.
//  - else queue non-empty -> pop head. Live head: WE3<=1, A3/WD3<=head. Squashed head: WE3<=0.
//  - else WE3<=0; A3/WD3 hold their previous values.
//  ALU with rd==0 counts as idle, so the queue may drain that cycle.
//  Latency: ALU sampled at edge N drives WE3 during N..N+1; Reg_Bank commits at N+1. A load accepted at edge N pops no earlier than edge N+1 and commits at N+2.
//  WAW rule (loads are always older than a concurrent or later ALU write):
//  - a valid ALU write to rd clears live on every queued entry with that rd;
//  - a load to the same rd enqueued in the same cycle is enqueued squashed.
//  - Squashed entries keep their slot until popped.
//  Simultaneous push+pop when not full: lq_count unchanged.
//  Pointer arithmetic is modulo LQ_DEPTH; lq_count never exceeds LQ_DEPTH or goes below 0.
//  ld_pend: OR over live entries of onehot(rd); bit 0 always 0; registered (updated with queue state).
//  At most one write per cycle; queued loads write in acceptance order.
// STRUCTURE
//  Shared package rb_pkg:
//  - XLEN and REG_AW defaults;
//  - typedef struct packed {logic live; logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;} wb_entry_t.
//  Sub-module wb_fifo: circular buffer of wb_entry_t with push/pop/count and a squash-by-rd port that clears live in parallel.
//  Top level holds the select mux, the output registers and the ld_pend reduction.
// TESTING
//  1 Reset, then alu_valid rd=3 data=AAAA1111 for one cycle -> next cycle WE3=1 A3=3 WD3=AAAA1111; Reg_Bank x3 reads AAAA1111.
//  2 alu rd=0 data=FFFFFFFF, concurrent ld rd=0 -> WE3 stays 0, lq_count stays 0, x0 reads 0.
//  3 Four loads rd=5..8 while ALU busy rd=9 every cycle -> lq_count=4, ld_ready=0, ld_pend=0x1E0. Release ALU -> four writes x5..x8 in order, lq_count back to 0.
//  4 Queue load rd=7 data=DEADBEEF, then ALU rd=7 data=12345678 -> ld_pend[7] clears; pop gives WE3=0; x7 reads 12345678.
//  5 Full queue with a pop and ld_valid in the same cycle -> load not accepted (ld_ready=0) and retried next cycle; lq_count decrements by 1.
//  6 Three loads queued, then rst high for one cycle -> WE3=0, lq_count=0, ld_pend=0; no queued register is written afterwards.

Source files
------------

// File: rtl/rb_pkg.sv
// rtl/rb_pkg.sv - shared widths and queue entry type for the register-bank writeback path
package rb_pkg;

  localparam int RB_XLEN   = 32;
  localparam int RB_REG_AW = 5;

  typedef struct packed {
    logic                 live;
    logic [RB_REG_AW-1:0] rd;
    logic [RB_XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular load queue with parallel squash-by-rd of queued entries
module wb_fifo
  import rb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push,
  input  logic [RB_REG_AW-1:0]                  push_rd,
  input  logic [RB_XLEN-1:0]                    push_data,
  input  logic                                  pop,
  input  logic                                  squash_valid,
  input  logic [RB_REG_AW-1:0]                  squash_rd,
  output wb_entry_t                             head,
  output logic [$clog2(DEPTH):0]                count,
  output logic [DEPTH-1:0]                      live_vec,
  output logic [DEPTH-1:0][RB_REG_AW-1:0]       rd_vec
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  // Popped slots drop live so the pending mask only ever sees occupied entries.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (squash_valid && (mem_q[i].rd == squash_rd)) mem_d[i].live = 1'b0;
    end
    if (pop_ok) begin
      mem_d[rd_ptr_q].live = 1'b0;
      rd_ptr_d             = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      mem_d[wr_ptr_q].live = !(squash_valid && (squash_rd == push_rd));
      mem_d[wr_ptr_q].rd   = push_rd;
      mem_d[wr_ptr_q].data = push_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    live_vec = '0;
    rd_vec   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_vec[i] = mem_q[i].live;
      rd_vec[i]   = mem_q[i].rd;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/reg_bank_writeback.sv
// rtl/reg_bank_writeback.sv - merges ALU and queued load results onto the single register-bank write port
module reg_bank_writeback
  import rb_pkg::*;
#(
  parameter int XLEN     = RB_XLEN,
  parameter int REG_AW   = RB_REG_AW,
  parameter int LQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [REG_AW-1:0]         alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [REG_AW-1:0]         ld_rd,
  input  logic [XLEN-1:0]           ld_data,
  output logic                      WE3,
  output logic [REG_AW-1:0]         A3,
  output logic [XLEN-1:0]           WD3,
  output logic [$clog2(LQ_DEPTH):0] lq_count,
  output logic [2**REG_AW-1:0]      ld_pend
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic                               alu_wr, push, pop;
  wb_entry_t                          head;
  logic [LQ_DEPTH-1:0]                live_vec;
  logic [LQ_DEPTH-1:0][REG_AW-1:0]    rd_vec;
  logic                               we3_q, we3_d;
  logic [REG_AW-1:0]                  a3_q, a3_d;
  logic [XLEN-1:0]                    wd3_q, wd3_d;

  // A write to x0 is architecturally a no-op, so it neither claims the port nor squashes.
  assign alu_wr   = alu_valid && (alu_rd != '0);
  assign ld_ready = (lq_count != CW'(LQ_DEPTH));
  assign push     = ld_valid && ld_ready && (ld_rd != '0);
  assign pop      = !alu_wr && (lq_count != '0);

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_rd      (ld_rd),
    .push_data    (ld_data),
    .pop          (pop),
    .squash_valid (alu_wr),
    .squash_rd    (alu_rd),
    .head         (head),
    .count        (lq_count),
    .live_vec     (live_vec),
    .rd_vec       (rd_vec)
  );

  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (alu_wr) begin
      we3_d = 1'b1;
      a3_d  = alu_rd;
      wd3_d = alu_data;
    end else if (pop) begin
      we3_d = head.live;
      if (head.live) begin
        a3_d  = head.rd;
        wd3_d = head.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
    end
  end

  always_comb begin
    ld_pend = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (live_vec[i]) ld_pend[rd_vec[i]] = 1'b1;
    end
    ld_pend[0] = 1'b0;
  end

  assign WE3 = we3_q;
  assign A3  = a3_q;
  assign WD3 = wd3_q;

endmodule
